operand_aligner: RTL and testbench
==================================

# operand_aligner

Front-end stage of the FP add/sub datapath, the counterpart to the normalize/round back end. Accepts two IEEE 754 operands and an add/sub opcode, unpacks them, orders them by magnitude, and right-aligns the smaller mantissa to the larger exponent, one bit per cycle, with guard and sticky tracking. Produces the extended-mantissa format the normalizer consumes. Uses a valid/ready handshake on both sides.

## Interface
- `EXP_BITS`, default 8: exponent width.
- `MANT_BITS`, default 23: stored fraction width.
- `WIDTH`, default 32: operand width, equal to 1+EXP_BITS+MANT_BITS.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept.
- `a`, `b` input WIDTH: IEEE 754 operands.
- `op` input 1: 0 = a+b, 1 = a−b.
- `out_valid` output 1: aligned result valid.
- `out_ready` input 1: downstream accepts.
- `exp_out` output EXP_BITS: larger (effective) exponent.
- `mant_big`, `mant_small` output MANT_BITS+4: aligned mantissas in extended format.
- `sign_big` output 1: sign of larger-magnitude operand, after `op` is applied.
- `eff_sub` output 1: sign_a ^ sign_b ^ op.
- `special` output 1: NaN/Inf bypass; only exists under the macro.

## Operation
- Extended format, for N = MANT_BITS+4:
  - [N-1] is a zero headroom bit.
  - [N-2] is the hidden bit.
  - [N-3:2] is the fraction.
  - [1] is the guard bit.
  - [0] is the sticky bit.
- Unpack rules:
  - exp==0 (subnormal or zero): hidden bit = 0, effective exponent = 1.
  - Otherwise: hidden bit = 1.
  - The sign of b is inverted when op=1.
- States and transitions:
  - IDLE: `in_ready`=1. On in_valid&&in_ready, register a, b, op → COMPARE.
  - COMPARE (1 cycle):
    - Compare {exp,frac} unsigned. Larger goes to big; on a tie, a goes to big.
    - d = exp_big − exp_small (effective exponents).
    - d==0 → DONE.
    - d ≥ MANT_BITS+3 → mant_small = {0…0, |small}, then DONE.
    - Otherwise, count = d → SHIFT.
  - SHIFT, once per cycle:
    - mant_small ← {0, mant_small[N-1:1]}, with new bit[0] = old bit[1] | old bit[0].
    - count−1. When count reaches 1, the cycle shifts and then goes → DONE.
  - DONE: `out_valid`=1 with outputs held stable. On out_ready → IDLE.
- `in_ready` is 0 in every state except IDLE. No new operand is accepted while a result is pending.
- Reset values: state=IDLE, in_ready=1, out_valid=0, all data outputs 0, count=0.
- Reset asserted mid-COMPARE, SHIFT or DONE returns to IDLE immediately. Any pending result is discarded.

## Timing
- Accept edge = cycle T. COMPARE runs in T+1.
- `out_valid` rises at:
  - T+2 when d==0 or d ≥ MANT_BITS+3.
  - T+2+d when 0<d<MANT_BITS+3.
- Worst case: T+2+MANT_BITS+2, i.e. T+27 at the defaults.
- Output handshake at edge U → in_ready=1 at U+1. Minimum issue interval is 3 cycles.
- All outputs are registered. There is no combinational path from any input to out_valid or the data outputs.
- `in_ready` depends only on state.

## Configuration
- Macro: `OPERAND_ALIGNER_SPECIAL_EN`.
- Defined: COMPARE detects exp==all-ones on either operand and goes straight to DONE with `special`=1.
  - mant_big encodes the result: NaN if any operand is NaN or if Inf−Inf under eff_sub; Inf otherwise.
  - exp_out = all-ones.
  - sign_big follows the Inf operand.
- Undefined: the `special` port and its logic are absent. All-ones exponents are aligned as ordinary numbers.

## Test plan
- a=0x3F800000, b=0x3F800000, op=0 → out_valid at T+2; exp_out=0x7F; mant_big=mant_small=0x2000000; eff_sub=0.
- a=0x3F800000, b=0x3E800000, op=0 → d=2; out_valid at T+4; mant_small=0x0800000; exp_out=0x7F.
- a=0x3F800000, b=0x30800000, op=1 → d=30 collapses to sticky; out_valid at T+2; mant_small=0x0000001; eff_sub=1.
- a=0x3E800000, b=0x3F800000, op=0 → swap: sign_big=0, mant_big=0x2000000, mant_small=0x0800000. Then hold out_ready=0 for 5 cycles → outputs stable, in_ready=0 throughout.
- Assert rst_n=0 during SHIFT (a=0x3F800000, b=0x3C000000, d=7) → same-cycle out_valid=0, in_ready=1. A new pair accepted after release completes normally.
- With the macro: a=0x7F800000, b=0x7F800000, op=1 → special=1, exp_out=0xFF, NaN mantissa, at T+2.

Source files
------------

// File: rtl/operand_aligner.sv
// operand_aligner: FP add/sub front end. Unpacks two IEEE 754 operands,
// orders them by magnitude and right-aligns the smaller mantissa to the
// larger exponent one bit per cycle, tracking guard and sticky bits.
// Extended mantissa layout (N = MANT_BITS+4):
//   [N-1] headroom, [N-2] hidden, [N-3:2] fraction, [1] guard, [0] sticky.
// Optional NaN/Inf bypass and the `special` port: OPERAND_ALIGNER_SPECIAL_EN.
module operand_aligner #(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MANT_BITS = 23,
  parameter int unsigned WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_BITS-1:0]    exp_out,
  output logic [MANT_BITS+3:0]   mant_big,
  output logic [MANT_BITS+3:0]   mant_small,
  output logic                   sign_big,
`ifdef OPERAND_ALIGNER_SPECIAL_EN
  output logic                   special,
`endif
  output logic                   eff_sub
);

  localparam int unsigned N      = MANT_BITS + 4;
  localparam int unsigned SH_MAX = MANT_BITS + 3;
  localparam int unsigned CNT_W  = $clog2(SH_MAX);
  localparam int unsigned MAG_W  = WIDTH - 1;

`ifdef OPERAND_ALIGNER_SPECIAL_EN
  localparam logic [N-1:0] MANT_INF  = {2'b01, (N-2)'(0)};
  localparam logic [N-1:0] MANT_QNAN = {3'b011, (N-3)'(0)};
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 op_q, op_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [EXP_BITS-1:0]  exp_out_q, exp_out_d;
  logic [N-1:0]         mant_big_q, mant_big_d;
  logic [N-1:0]         mant_small_q, mant_small_d;
  logic                 sign_big_q, sign_big_d;
  logic                 eff_sub_q, eff_sub_d;
`ifdef OPERAND_ALIGNER_SPECIAL_EN
  logic                 special_q, special_d;
`endif

  // Unpacked view of the captured operands (sign of b already reflects op).
  logic                 sign_a_c, sign_b_c;
  logic [EXP_BITS-1:0]  exp_a_c, exp_b_c;
  logic [MANT_BITS-1:0] frac_a_c, frac_b_c;
  logic [EXP_BITS-1:0]  eexp_a_c, eexp_b_c;
  logic [N-1:0]         mant_a_c, mant_b_c;
  logic                 a_is_big_c;
  logic [EXP_BITS-1:0]  eexp_big_c, eexp_small_c, diff_c;
  logic [N-1:0]         mbig_c, msmall_c;
  logic                 sbig_c;

  // Unpack, magnitude-order and compute the exponent difference.
  always_comb begin
    sign_a_c     = a_q[WIDTH-1];
    sign_b_c     = b_q[WIDTH-1] ^ op_q;
    exp_a_c      = a_q[WIDTH-2 -: EXP_BITS];
    exp_b_c      = b_q[WIDTH-2 -: EXP_BITS];
    frac_a_c     = a_q[MANT_BITS-1:0];
    frac_b_c     = b_q[MANT_BITS-1:0];
    eexp_a_c     = (exp_a_c == '0) ? EXP_BITS'(1) : exp_a_c;
    eexp_b_c     = (exp_b_c == '0) ? EXP_BITS'(1) : exp_b_c;
    mant_a_c     = {1'b0, (exp_a_c != '0), frac_a_c, 2'b00};
    mant_b_c     = {1'b0, (exp_b_c != '0), frac_b_c, 2'b00};
    // Ties keep a as the big operand.
    a_is_big_c   = (a_q[MAG_W-1:0] >= b_q[MAG_W-1:0]);
    eexp_big_c   = a_is_big_c ? eexp_a_c : eexp_b_c;
    eexp_small_c = a_is_big_c ? eexp_b_c : eexp_a_c;
    mbig_c       = a_is_big_c ? mant_a_c : mant_b_c;
    msmall_c     = a_is_big_c ? mant_b_c : mant_a_c;
    sbig_c       = a_is_big_c ? sign_a_c : sign_b_c;
    diff_c       = eexp_big_c - eexp_small_c;
  end

`ifdef OPERAND_ALIGNER_SPECIAL_EN
  logic a_inf_c, b_inf_c, a_nan_c, b_nan_c, any_special_c, is_nan_c;

  // NaN/Inf classification for the bypass path.
  always_comb begin
    a_inf_c       = (exp_a_c == '1) && (frac_a_c == '0);
    b_inf_c       = (exp_b_c == '1) && (frac_b_c == '0);
    a_nan_c       = (exp_a_c == '1) && (frac_a_c != '0);
    b_nan_c       = (exp_b_c == '1) && (frac_b_c != '0);
    any_special_c = (exp_a_c == '1) || (exp_b_c == '1);
    is_nan_c      = a_nan_c || b_nan_c ||
                    (a_inf_c && b_inf_c && (sign_a_c ^ sign_b_c));
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    count_d      = count_q;
    exp_out_d    = exp_out_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    sign_big_d   = sign_big_q;
    eff_sub_d    = eff_sub_q;
`ifdef OPERAND_ALIGNER_SPECIAL_EN
    special_d    = special_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        exp_out_d  = eexp_big_c;
        mant_big_d = mbig_c;
        sign_big_d = sbig_c;
        eff_sub_d  = sign_a_c ^ sign_b_c;
        count_d    = '0;
`ifdef OPERAND_ALIGNER_SPECIAL_EN
        special_d  = 1'b0;
        if (any_special_c) begin
          special_d    = 1'b1;
          exp_out_d    = '1;
          mant_big_d   = is_nan_c ? MANT_QNAN : MANT_INF;
          mant_small_d = '0;
          sign_big_d   = a_inf_c ? sign_a_c : sign_b_c;
          state_d      = S_DONE;
        end else
`endif
        if (diff_c == '0) begin
          mant_small_d = msmall_c;
          state_d      = S_DONE;
        end else if (32'(diff_c) >= SH_MAX) begin
          // Everything would be shifted out: collapse to the sticky bit.
          mant_small_d = {(N-1)'(0), |msmall_c};
          state_d      = S_DONE;
        end else begin
          mant_small_d = msmall_c;
          count_d      = CNT_W'(diff_c);
          state_d      = S_SHIFT;
        end
      end

      S_SHIFT: begin
        mant_small_d = {1'b0, mant_small_q[N-1:2],
                        mant_small_q[1] | mant_small_q[0]};
        count_d      = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      count_q      <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      exp_out_q    <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
      sign_big_q   <= 1'b0;
      eff_sub_q    <= 1'b0;
`ifdef OPERAND_ALIGNER_SPECIAL_EN
      special_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      exp_out_q    <= exp_out_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      sign_big_q   <= sign_big_d;
      eff_sub_q    <= eff_sub_d;
`ifdef OPERAND_ALIGNER_SPECIAL_EN
      special_q    <= special_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign exp_out    = exp_out_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign sign_big   = sign_big_q;
  assign eff_sub    = eff_sub_q;
`ifdef OPERAND_ALIGNER_SPECIAL_EN
  assign special    = special_q;
`endif

endmodule

// File: tb/tb_operand_aligner.sv
// Directed bench for operand_aligner with hand-computed expectations.
module tb_operand_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [26:0] mant_big, mant_small;
  logic        sign_big;
  logic        eff_sub;
`ifdef OPERAND_ALIGNER_SPECIAL_EN
  logic        special;
`endif

  int n_vec = 0;
  int n_err = 0;

  operand_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_out    (exp_out),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .sign_big   (sign_big),
`ifdef OPERAND_ALIGNER_SPECIAL_EN
    .special    (special),
`endif
    .eff_sub    (eff_sub)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Present one operand pair, return the edge index (relative to the accept
  // edge) at which out_valid is first high.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                       output int lat);
    @(negedge clk);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vop, input int lat_w, input logic [7:0] e_w,
                        input logic [26:0] mb_w, input logic [26:0] ms_w,
                        input logic sb_w, input logic es_w);
    int lat;
    issue(va, vb, vop, lat);
    check({tag, ".lat"},        32'(lat),        32'(lat_w));
    check({tag, ".exp_out"},    32'(exp_out),    32'(e_w));
    check({tag, ".mant_big"},   32'(mant_big),   32'(mb_w));
    check({tag, ".mant_small"}, 32'(mant_small), 32'(ms_w));
    check({tag, ".sign_big"},   32'(sign_big),   32'(sb_w));
    check({tag, ".eff_sub"},    32'(eff_sub),    32'(es_w));
`ifdef OPERAND_ALIGNER_SPECIAL_EN
    check({tag, ".special"},    32'(special),    32'd0);
`endif
    drain(tag);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 1'b0;
    #12;
    check("rst.in_ready",   32'(in_ready),   32'd1);
    check("rst.out_valid",  32'(out_valid),  32'd0);
    check("rst.exp_out",    32'(exp_out),    32'd0);
    check("rst.mant_big",   32'(mant_big),   32'd0);
    check("rst.mant_small", 32'(mant_small), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_vec("eq",      32'h3F800000, 32'h3F800000, 1'b0, 2, 8'h7F, 27'h2000000, 27'h2000000, 1'b0, 1'b0);
    do_vec("d2",      32'h3F800000, 32'h3E800000, 1'b0, 4, 8'h7F, 27'h2000000, 27'h0800000, 1'b0, 1'b0);
    do_vec("d30",     32'h3F800000, 32'h30800000, 1'b1, 2, 8'h7F, 27'h2000000, 27'h0000001, 1'b0, 1'b1);
    do_vec("guard",   32'h3F800000, 32'h3F400001, 1'b0, 3, 8'h7F, 27'h2000000, 27'h1800002, 1'b0, 1'b0);
    do_vec("sticky",  32'h3F800000, 32'h3E800001, 1'b0, 4, 8'h7F, 27'h2000000, 27'h0800001, 1'b0, 1'b0);
    do_vec("d25",     32'h3F800000, 32'h33000000, 1'b0, 27, 8'h7F, 27'h2000000, 27'h0000001, 1'b0, 1'b0);
    do_vec("d26",     32'h3F800000, 32'h32800000, 1'b0, 2, 8'h7F, 27'h2000000, 27'h0000001, 1'b0, 1'b0);
    do_vec("subn",    32'h00000001, 32'h00000000, 1'b0, 2, 8'h01, 27'h0000004, 27'h0000000, 1'b0, 1'b0);
    do_vec("negsub",  32'h3F800000, 32'hC0000000, 1'b1, 3, 8'h80, 27'h2000000, 27'h1000000, 1'b0, 1'b0);

    // Swap case, then hold the result under back-pressure.
    issue(32'h3E800000, 32'h3F800000, 1'b0, lat);
    check("swap.lat",        32'(lat),        32'd4);
    check("swap.sign_big",   32'(sign_big),   32'd0);
    check("swap.mant_big",   32'(mant_big),   32'h2000000);
    check("swap.mant_small", 32'(mant_small), 32'h0800000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.out_valid",  32'(out_valid),  32'd1);
      check("hold.in_ready",   32'(in_ready),   32'd0);
      check("hold.mant_small", 32'(mant_small), 32'h0800000);
      check("hold.exp_out",    32'(exp_out),    32'h7F);
    end
    drain("swap");

    // Reset in the middle of a d=7 alignment.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3C000000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid.busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    check("mid.still_idle", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    do_vec("post", 32'h3F800000, 32'h3C000000, 1'b0, 9, 8'h7F, 27'h2000000, 27'h0040000, 1'b0, 1'b0);

`ifdef OPERAND_ALIGNER_SPECIAL_EN
    issue(32'h7F800000, 32'h7F800000, 1'b1, lat);
    check("spc.lat",      32'(lat),      32'd2);
    check("spc.special",  32'(special),  32'd1);
    check("spc.exp_out",  32'(exp_out),  32'hFF);
    check("spc.mant_big", 32'(mant_big), 32'h3000000);
    check("spc.eff_sub",  32'(eff_sub),  32'd1);
    drain("spc");
    issue(32'hFF800000, 32'h3F800000, 1'b0, lat);
    check("inf.lat",      32'(lat),      32'd2);
    check("inf.special",  32'(special),  32'd1);
    check("inf.mant_big", 32'(mant_big), 32'h2000000);
    check("inf.sign_big", 32'(sign_big), 32'd1);
    drain("inf");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
